// File: rtl/nios2_system_div_pkg.sv
// Shared definitions for the Nios II iterative divider: state encoding,
// default widths and the divide-by-zero quotient.
package nios2_system_div_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = {DIV_DATA_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } div_state_t;

  function automatic int count_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/nios2_system_div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one and
// subtract the divisor from the partial remainder when it fits.
module nios2_system_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
  logic [DATA_W:0] rem_shift_s;
  logic [DATA_W:0] trial_s;

  // Trial subtraction and quotient-bit selection
  always_comb begin
    rem_shift_s = {rem_in, quo_in[DATA_W-1]};
    trial_s     = rem_shift_s - {1'b0, divisor};
    if (trial_s[DATA_W]) begin
      rem_out = rem_shift_s[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end else begin
      rem_out = trial_s[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/nios2_system_div_cell.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per clock,
// with a start/busy/done handshake for the Nios II divide path.
module nios2_system_div_cell
  import nios2_system_div_pkg::*;
#(
  parameter int                DATA_W    = DIV_DATA_W,
  parameter logic [DATA_W-1:0] ZERO_QUOT = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] A_div_src1,
  input  logic [DATA_W-1:0] A_div_src2,
  input  logic              A_div_signed,
  input  logic              A_div_start,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_quot,
  output logic [DATA_W-1:0] A_div_rem,
  output logic              A_div_dz
);

  localparam int COUNT_W = count_w(DATA_W);

  div_state_t         state_r;
  div_state_t         state_nx_s;
  logic [COUNT_W-1:0] cnt_r;
  logic               sa_r;
  logic               sb_r;
  logic               zero_r;
  logic [DATA_W-1:0]  src1_r;
  logic [DATA_W-1:0]  divisor_r;
  logic [DATA_W-1:0]  rem_r;
  logic [DATA_W-1:0]  quo_r;
  logic [DATA_W-1:0]  quot_out_r;
  logic [DATA_W-1:0]  rem_out_r;
  logic               done_r;
  logic               dz_r;

  logic               neg_a_s;
  logic               neg_b_s;
  logic [DATA_W-1:0]  mag_a_s;
  logic [DATA_W-1:0]  mag_b_s;
  logic [DATA_W-1:0]  rem_step_s;
  logic [DATA_W-1:0]  quo_step_s;
  logic               last_s;

  // Magnitudes are plain unsigned, so the most negative value maps onto itself.
  assign neg_a_s = A_div_signed & A_div_src1[DATA_W-1];
  assign neg_b_s = A_div_signed & A_div_src2[DATA_W-1];
  assign mag_a_s = neg_a_s ? -A_div_src1 : A_div_src1;
  assign mag_b_s = neg_b_s ? -A_div_src2 : A_div_src2;
  assign last_s  = (cnt_r == COUNT_W'(DATA_W-1));

  nios2_system_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (divisor_r),
    .rem_out (rem_step_s),
    .quo_out (quo_step_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (A_div_start) state_nx_s = CALC;
        else             state_nx_s = IDLE;
      end
      CALC: begin
        if (last_s) state_nx_s = FIXUP;
        else        state_nx_s = CALC;
      end
      FIXUP:   state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand capture, iteration and sign fixup of the result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= {COUNT_W{1'b0}};
      sa_r       <= 1'b0;
      sb_r       <= 1'b0;
      zero_r     <= 1'b0;
      src1_r     <= {DATA_W{1'b0}};
      divisor_r  <= {DATA_W{1'b0}};
      rem_r      <= {DATA_W{1'b0}};
      quo_r      <= {DATA_W{1'b0}};
      quot_out_r <= {DATA_W{1'b0}};
      rem_out_r  <= {DATA_W{1'b0}};
      done_r     <= 1'b0;
      dz_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (A_div_start) begin
            sa_r      <= neg_a_s;
            sb_r      <= neg_b_s;
            quo_r     <= mag_a_s;
            divisor_r <= mag_b_s;
            zero_r    <= (A_div_src2 == {DATA_W{1'b0}});
            src1_r    <= A_div_src1;
            rem_r     <= {DATA_W{1'b0}};
            cnt_r     <= {COUNT_W{1'b0}};
          end
        end
        CALC: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          cnt_r <= cnt_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
        FIXUP: begin
          done_r <= 1'b1;
          if (zero_r) begin
            quot_out_r <= ZERO_QUOT;
            rem_out_r  <= src1_r;
            dz_r       <= 1'b1;
          end else begin
            // Remainder takes the sign of the dividend (truncating division).
            quot_out_r <= (sa_r ^ sb_r) ? -quo_r : quo_r;
            rem_out_r  <= sa_r ? -rem_r : rem_r;
            dz_r       <= 1'b0;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign A_div_busy = (state_r != IDLE);
  assign A_div_done = done_r;
  assign A_div_quot = quot_out_r;
  assign A_div_rem  = rem_out_r;
  assign A_div_dz   = dz_r;

endmodule

// File: tb/tb_nios2_system_div_cell.sv
// Self-checking bench for nios2_system_div_cell: directed vector table,
// handshake corner cases and a batch of random operands against a reference.
module tb_nios2_system_div_cell;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] src1  = 32'd0;
  logic [31:0] src2  = 32'd0;
  logic        sgn   = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        dz;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nios2_system_div_cell dut (
    .clk          (clk),
    .reset        (reset),
    .A_div_src1   (src1),
    .A_div_src2   (src2),
    .A_div_signed (sgn),
    .A_div_start  (start),
    .A_div_busy   (busy),
    .A_div_done   (done),
    .A_div_quot   (quot),
    .A_div_rem    (rem),
    .A_div_dz     (dz)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called right after a falling edge: the next rising edge ends cycle 0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    src1  = a;
    src2  = b;
    sgn   = s;
    start = 1'b1;
  endtask

  // Walks cycles 1..34 after a start and returns at the done cycle, so a
  // following start_op lands exactly in the done cycle.
  task automatic wait_result(input string name, input logic [31:0] eq, input logic [31:0] er,
                             input logic edz, input bit interfere);
    int busy_bad = 0;
    int done_cnt = 0;
    int done_at  = -1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (interfere && k == 10) start_op(32'd9, 32'd3, 1'b0);
      if (interfere && k == 11) start = 1'b0;
      if (busy !== (k <= 33)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
    end
    chk({name, " busy pattern errors"}, busy_bad, 32'd0);
    chk({name, " done count"}, done_cnt, 32'd1);
    chk({name, " done cycle"}, done_at, 32'd34);
    chk({name, " quot"}, quot, eq);
    chk({name, " rem"}, rem, er);
    chk({name, " dz"}, {31'd0, dz}, {31'd0, edz});
  endtask

  initial begin
    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2] = '{32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0};
    vecs[3] = '{32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[4] = '{32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[5] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
    vecs[6] = '{32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
    vecs[7] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[8] = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[9] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quot", quot, 32'd0);
    chk("reset rem", rem, 32'd0);
    chk("reset dz", {31'd0, dz}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);
    end

    // Start while busy is ignored; a start in the done cycle is accepted.
    start_op(32'd100, 32'd7, 1'b0);
    wait_result("ignored start", 32'd14, 32'd2, 1'b0, 1'b1);
    start_op(32'd9, 32'd3, 1'b0);
    wait_result("chained start", 32'd3, 32'd0, 1'b0, 1'b0);

    // Reset in cycle 15 of an operation aborts it.
    start_op(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 14) chk("held quot during calc", quot, 32'd3);
      if (k == 15) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort quot", quot, 32'd0);
    chk("abort rem", rem, 32'd0);
    begin
      int late_done = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done === 1'b1) late_done++;
      end
      chk("abort no done", late_done, 32'd0);
    end
    start_op(32'd100, 32'd7, 1'b0);
    wait_result("after abort", 32'd14, 32'd2, 1'b0, 1'b0);

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    start_op(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("reset vs start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("reset vs start idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        s;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      s = 1'($urandom_range(0, 1));
      if (b == 32'd0) b = 32'd1;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
      start_op(a, b, s);
      wait_result($sformatf("rand%0d", i), q, r, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
